// File: rtl/sweep_tracker.sv
// -----------------------------------------------------------------------------
// sweep_tracker
//
// Tracks a servo sweep and remembers where the brightest light sample was
// seen, then guides a return move back to that position.
//
// A sweep starts on a rising edge of HS or VS, which clears the position,
// the best sample and the DONE flag. During the sweep each STEP advances POS.
// Each valid LIGHT sample brighter than the best so far is captured together
// with the position it was taken at. After SWEEP_STEPS steps DONE sets and
// the sweep-incomplete flag drops. With MC high each STEP walks POS back
// down until it reaches MAX_POS.
//
// Build option:
//   SWEEP_TRACKER_HYST_EN - when defined, a new sample must beat the best
//                           value by more than HYST to be captured. The
//                           first valid sample of a sweep always captures.
//
// Parameters:
//   SWEEP_STEPS  step ticks in one full sweep (1..255)
//   HYST         capture hysteresis margin (used only with the macro above)
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   HS, VS     in   horizontal / vertical sweep enables (HS wins if both set)
//   MC         in   return-to-max enable
//   CNT_RST    in   synchronous clear, active-high, overrides everything
//   STEP       in   single-cycle servo step tick
//   LIGHT      in   12-bit light sample, qualified by LIGHT_VLD
//   CNT_L      out  horizontal sweep incomplete (HS & ~DONE)
//   CNT_D      out  vertical sweep incomplete (VS & ~HS & ~DONE)
//   CNT_RU     out  return move incomplete (MC & POS != MAX_POS)
//   POS        out  current step position
//   MAX_POS    out  position of the best sample
//   MAX_VAL    out  best sample value
// -----------------------------------------------------------------------------
module sweep_tracker #(
  parameter int unsigned SWEEP_STEPS = 180,
  parameter int unsigned HYST        = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        HS,
  input  logic        VS,
  input  logic        MC,
  input  logic        CNT_RST,
  input  logic        STEP,
  input  logic [11:0] LIGHT,
  input  logic        LIGHT_VLD,
  output logic        CNT_L,
  output logic        CNT_D,
  output logic        CNT_RU,
  output logic [7:0]  POS,
  output logic [7:0]  MAX_POS,
  output logic [11:0] MAX_VAL
);

  // Elaboration-time range guard on the configuration.
  if (SWEEP_STEPS < 1 || SWEEP_STEPS > 255 || HYST > 4095) begin : g_param_check
    $error("sweep_tracker: SWEEP_STEPS must be 1..255 and HYST at most 4095");
  end

  localparam logic [7:0] LAST_POS = 8'(SWEEP_STEPS - 1);

  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        done_q, done_d;
  logic [7:0]  pos_q, pos_d;
  logic [7:0]  max_pos_q, max_pos_d;
  logic [11:0] max_val_q, max_val_d;

  logic vs_eff;     // VS with HS priority applied
  logic sweep_act;
  logic start;
  logic light_gt;

  assign vs_eff    = VS & ~HS;
  assign sweep_act = HS | vs_eff;
  // Edges are taken against the registered enables so a sweep start is seen
  // exactly once; HS dropping while VS stays high counts as a VS start.
  assign start     = (HS & ~hs_q) | (vs_eff & ~vs_q);

`ifdef SWEEP_TRACKER_HYST_EN
  logic        seen_q, seen_d;   // a sample has been captured this sweep
  logic [12:0] thresh;

  // 13-bit sum so MAX_VAL + HYST never wraps.
  assign thresh   = {1'b0, max_val_q} + 13'(HYST);
  assign light_gt = ~seen_q | ({1'b0, LIGHT} > thresh);
`else
  assign light_gt = LIGHT > max_val_q;
`endif

  always_comb begin
    hs_d      = HS;
    vs_d      = vs_eff;
    done_d    = done_q;
    pos_d     = pos_q;
    max_pos_d = max_pos_q;
    max_val_d = max_val_q;
`ifdef SWEEP_TRACKER_HYST_EN
    seen_d    = seen_q;
`endif
    if (CNT_RST) begin
      hs_d      = 1'b0;
      vs_d      = 1'b0;
      done_d    = 1'b0;
      pos_d     = '0;
      max_pos_d = '0;
      max_val_d = '0;
`ifdef SWEEP_TRACKER_HYST_EN
      seen_d    = 1'b0;
`endif
    end else if (start) begin
      // STEP and LIGHT_VLD in the start cycle are deliberately dropped.
      done_d    = 1'b0;
      pos_d     = '0;
      max_pos_d = '0;
      max_val_d = '0;
`ifdef SWEEP_TRACKER_HYST_EN
      seen_d    = 1'b0;
`endif
    end else if (sweep_act) begin
      if (!done_q) begin
        // Capture uses the pre-increment position; strict compare keeps
        // the earlier position on ties.
        if (LIGHT_VLD && light_gt) begin
          max_val_d = LIGHT;
          max_pos_d = pos_q;
`ifdef SWEEP_TRACKER_HYST_EN
          seen_d    = 1'b1;
`endif
        end
        if (STEP) begin
          pos_d = pos_q + 8'd1;
          if (pos_q == LAST_POS) begin
            done_d = 1'b1;
          end
        end
      end
    end else if (MC && STEP && (pos_q != max_pos_q)) begin
      pos_d = pos_q - 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      done_q    <= 1'b0;
      pos_q     <= '0;
      max_pos_q <= '0;
      max_val_q <= '0;
`ifdef SWEEP_TRACKER_HYST_EN
      seen_q    <= 1'b0;
`endif
    end else begin
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      done_q    <= done_d;
      pos_q     <= pos_d;
      max_pos_q <= max_pos_d;
      max_val_q <= max_val_d;
`ifdef SWEEP_TRACKER_HYST_EN
      seen_q    <= seen_d;
`endif
    end
  end

  assign CNT_L   = HS & ~done_q;
  assign CNT_D   = vs_eff & ~done_q;
  assign CNT_RU  = MC & (pos_q != max_pos_q);
  assign POS     = pos_q;
  assign MAX_POS = max_pos_q;
  assign MAX_VAL = max_val_q;

endmodule

// File: tb/tb_sweep_tracker.sv
// -----------------------------------------------------------------------------
// tb_sweep_tracker
//
// Directed and randomised scenarios for sweep_tracker with SWEEP_STEPS=10.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1
// time unit after the edge. Expected {POS, MAX_POS, MAX_VAL} triples are
// pushed when a step is driven and popped after the edge that applies it.
// -----------------------------------------------------------------------------
module tb_sweep_tracker;

  localparam int unsigned N    = 10;
  localparam int unsigned HYST = 8;

  logic        CLK;
  logic        RST_N;
  logic        HS, VS, MC, CNT_RST, STEP, LIGHT_VLD;
  logic [11:0] LIGHT;
  logic        CNT_L, CNT_D, CNT_RU;
  logic [7:0]  POS, MAX_POS;
  logic [11:0] MAX_VAL;

  sweep_tracker #(.SWEEP_STEPS(N), .HYST(HYST)) dut (
    .CLK(CLK), .RST_N(RST_N), .HS(HS), .VS(VS), .MC(MC), .CNT_RST(CNT_RST),
    .STEP(STEP), .LIGHT(LIGHT), .LIGHT_VLD(LIGHT_VLD),
    .CNT_L(CNT_L), .CNT_D(CNT_D), .CNT_RU(CNT_RU),
    .POS(POS), .MAX_POS(MAX_POS), .MAX_VAL(MAX_VAL)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // scoreboard: {POS, MAX_POS, MAX_VAL}
  logic [27:0] exp_q[$];
  logic [27:0] exp_v;
  logic [27:0] got_v;

  // reference tracking state
  logic [7:0]  pos_m, mp_m;
  logic [11:0] mv_m;
  bit          seen_m;

  task automatic model_clear();
    pos_m = '0; mp_m = '0; mv_m = '0; seen_m = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One sweep step with an optional light sample; predicts the result.
  task automatic drive_sweep_step(input logic vld, input logic [11:0] lt);
    logic cap;
`ifdef SWEEP_TRACKER_HYST_EN
    cap = vld && (!seen_m || ({1'b0, lt} > ({1'b0, mv_m} + 13'(HYST))));
`else
    cap = vld && (lt > mv_m);
`endif
    if (cap) begin
      mv_m = lt; mp_m = pos_m; seen_m = 1'b1;
    end
    pos_m = pos_m + 8'd1;
    exp_q.push_back({pos_m, mp_m, mv_m});
    STEP = 1'b1; LIGHT_VLD = vld; LIGHT = lt;
    tick();
    STEP = 1'b0; LIGHT_VLD = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; HS = 1'b1; VS = 1'b1; MC = 1'b1; CNT_RST = 1'b0;
    STEP = 1'b0; LIGHT_VLD = 1'b0; LIGHT = '0;
    #1;
    checks++;
    if ({CNT_L, CNT_D, CNT_RU} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags_hs: got %b expected 100", {CNT_L, CNT_D, CNT_RU});
    end
    HS = 1'b0;
    #1;
    checks++;
    if ({CNT_L, CNT_D, CNT_RU} !== 3'b010) begin
      errors++;
      $display("FAIL reset_flags_vs: got %b expected 010", {CNT_L, CNT_D, CNT_RU});
    end
    VS = 1'b0; MC = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    checks++;
    if ({POS, MAX_VAL, CNT_L, CNT_RU} !== 22'd0) begin
      errors++;
      $display("FAIL reset_state: got pos=%0d max_val=%0d cnt_l=%b cnt_ru=%b expected all 0",
               POS, MAX_VAL, CNT_L, CNT_RU);
    end
  endtask

  task automatic test_sweep();
    // start cycle: STEP and a bright sample must be ignored
    HS = 1'b1; STEP = 1'b1; LIGHT_VLD = 1'b1; LIGHT = 12'd4000;
    model_clear();
    exp_q.push_back(28'd0);
    tick();
    STEP = 1'b0; LIGHT_VLD = 1'b0;
    exp_v = exp_q.pop_front(); got_v = {POS, MAX_POS, MAX_VAL};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL sweep_start: got %h expected %h", got_v, exp_v);
    end
    for (int p = 0; p < int'(N); p++) begin
      checks++;
      if (CNT_L !== 1'b1) begin
        errors++;
        $display("FAIL sweep_cnt_l: pos %0d got %b expected 1", p, CNT_L);
      end
      drive_sweep_step(1'b1, (p == 3) ? 12'd500 : 12'(p * 10));
      exp_v = exp_q.pop_front(); got_v = {POS, MAX_POS, MAX_VAL};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL sweep_step: pos %0d got %h expected %h", p, got_v, exp_v);
      end
    end
    checks++;
    if (CNT_L !== 1'b0) begin
      errors++;
      $display("FAIL sweep_cnt_l_done: got %b expected 0", CNT_L);
    end
    checks++;
    if ({POS, MAX_POS, MAX_VAL} !== {8'd10, 8'd3, 12'd500}) begin
      errors++;
      $display("FAIL sweep_result: got pos=%0d max_pos=%0d max_val=%0d expected 10/3/500",
               POS, MAX_POS, MAX_VAL);
    end
    // after DONE, steps and samples are ignored
    exp_q.push_back({pos_m, mp_m, mv_m});
    STEP = 1'b1; LIGHT_VLD = 1'b1; LIGHT = 12'd4095;
    tick();
    STEP = 1'b0; LIGHT_VLD = 1'b0;
    exp_v = exp_q.pop_front(); got_v = {POS, MAX_POS, MAX_VAL};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL step_after_done: got %h expected %h", got_v, exp_v);
    end
  endtask

  task automatic test_return();
    HS = 1'b0; MC = 1'b1;
    #1;
    checks++;
    if (CNT_RU !== 1'b1) begin
      errors++;
      $display("FAIL return_cnt_ru_start: got %b expected 1", CNT_RU);
    end
    for (int i = 0; i < 8; i++) begin
      if (pos_m != mp_m) pos_m = pos_m - 8'd1;
      exp_q.push_back({pos_m, mp_m, mv_m});
      STEP = 1'b1;
      tick();
      STEP = 1'b0;
      exp_v = exp_q.pop_front(); got_v = {POS, MAX_POS, MAX_VAL};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL return_step: step %0d got %h expected %h", i, got_v, exp_v);
      end
      checks++;
      if (CNT_RU !== (i < 6)) begin
        errors++;
        $display("FAIL return_cnt_ru: step %0d got %b expected %b", i, CNT_RU, (i < 6));
      end
    end
    checks++;
    if (POS !== 8'd3) begin
      errors++;
      $display("FAIL return_final_pos: got %0d expected 3", POS);
    end
  endtask

  task automatic test_vs_start();
    MC = 1'b0;
    tick();
    VS = 1'b1;
    #1;
    checks++;
    if (CNT_D !== 1'b0) begin
      errors++;
      $display("FAIL vs_cnt_d_before: got %b expected 0", CNT_D);
    end
    model_clear();
    exp_q.push_back(28'd0);
    tick();
    exp_v = exp_q.pop_front(); got_v = {POS, MAX_POS, MAX_VAL};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL vs_start: got %h expected %h", got_v, exp_v);
    end
    checks++;
    if (CNT_D !== 1'b1) begin
      errors++;
      $display("FAIL vs_cnt_d_after: got %b expected 1", CNT_D);
    end
  endtask

  task automatic test_ties();
    logic [11:0] lights [7];
    lights = '{12'd0, 12'd0, 12'd200, 12'd0, 12'd0, 12'd200, 12'd0};
`ifdef SWEEP_TRACKER_HYST_EN
    lights[5] = 12'd205;
`endif
    for (int p = 0; p < 7; p++) begin
      drive_sweep_step(1'b1, lights[p]);
      exp_v = exp_q.pop_front(); got_v = {POS, MAX_POS, MAX_VAL};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL tie_step: pos %0d got %h expected %h", p, got_v, exp_v);
      end
    end
    checks++;
    if ({MAX_POS, MAX_VAL} !== {8'd2, 12'd200}) begin
      errors++;
      $display("FAIL tie_result: got max_pos=%0d max_val=%0d expected 2/200", MAX_POS, MAX_VAL);
    end
  endtask

  task automatic test_idle_step();
    VS = 1'b0; HS = 1'b0; MC = 1'b0;
    exp_q.push_back({pos_m, mp_m, mv_m});
    STEP = 1'b1; LIGHT_VLD = 1'b1; LIGHT = 12'd3000;
    tick();
    STEP = 1'b0; LIGHT_VLD = 1'b0;
    exp_v = exp_q.pop_front(); got_v = {POS, MAX_POS, MAX_VAL};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL idle_step: got %h expected %h", got_v, exp_v);
    end
  endtask

  task automatic test_cnt_rst();
    HS = 1'b1;
    model_clear();
    tick();
    for (int p = 0; p < 6; p++) begin
      drive_sweep_step(1'b1, 12'(p * 20 + 100));
      exp_v = exp_q.pop_front(); got_v = {POS, MAX_POS, MAX_VAL};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL cnt_rst_pre: pos %0d got %h expected %h", p, got_v, exp_v);
      end
    end
    CNT_RST = 1'b1;
    exp_q.push_back(28'd0);
    tick();
    CNT_RST = 1'b0;
    exp_v = exp_q.pop_front(); got_v = {POS, MAX_POS, MAX_VAL};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL cnt_rst_clear: got %h expected %h", got_v, exp_v);
    end
    checks++;
    if (CNT_L !== 1'b1) begin
      errors++;
      $display("FAIL cnt_rst_cnt_l: got %b expected 1", CNT_L);
    end
    // HS_q was cleared, so the next edge is a fresh start
    model_clear();
    exp_q.push_back(28'd0);
    STEP = 1'b1;
    tick();
    STEP = 1'b0;
    exp_v = exp_q.pop_front(); got_v = {POS, MAX_POS, MAX_VAL};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL cnt_rst_restart: got %h expected %h", got_v, exp_v);
    end
    drive_sweep_step(1'b1, 12'd50);
    exp_v = exp_q.pop_front(); got_v = {POS, MAX_POS, MAX_VAL};
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL cnt_rst_resume: got %h expected %h", got_v, exp_v);
    end
  endtask

  task automatic test_random_sweep();
    HS = 1'b0;
    tick();
    HS = 1'b1;
    model_clear();
    tick();
    for (int p = 0; p < int'(N); p++) begin
      drive_sweep_step(1'($urandom_range(0, 3) != 0), 12'($urandom_range(0, 4095)));
      exp_v = exp_q.pop_front(); got_v = {POS, MAX_POS, MAX_VAL};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL random_step: pos %0d got %h expected %h", p, got_v, exp_v);
      end
    end
    checks++;
    if (CNT_L !== 1'b0) begin
      errors++;
      $display("FAIL random_cnt_l_done: got %b expected 0", CNT_L);
    end
  endtask

  task automatic test_reset_mid();
    HS = 1'b0;
    tick();
    HS = 1'b1;
    model_clear();
    tick();
    for (int p = 0; p < 3; p++) drive_sweep_step(1'b1, 12'(p * 100 + 100));
    exp_q.delete();
    #1;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({POS, MAX_POS, MAX_VAL, CNT_L} !== {28'd0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: got pos=%0d max_pos=%0d max_val=%0d cnt_l=%b expected 0/0/0/1",
               POS, MAX_POS, MAX_VAL, CNT_L);
    end
    HS = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    checks++;
    if ({POS, MAX_POS, MAX_VAL} !== 28'd0) begin
      errors++;
      $display("FAIL after_reset_mid: got pos=%0d max_pos=%0d max_val=%0d expected 0",
               POS, MAX_POS, MAX_VAL);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_return();
    test_vs_start();
    test_ties();
    test_idle_step();
    test_cnt_rst();
    test_random_sweep();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
